masked_rectangle_g_layer_3sh: RTL
=================================

// Module: masked_rectangle_g_layer_3sh
// PURPOSE
//  3-share, second-order masked RECTANGLE (G-class) S-box layer, no fresh randomness.
//  Takes a full 3-share state (NSBOX nibbles per share) and runs LANES masked S-boxes per cycle.
//  A chunk counter/FSM iterates over the state in place, with a valid/ready handshake on both sides.
//  Sits between the masked key-add and the masked ShiftRow stages of the round datapath.
// PARAMETERS
//  NSBOX   16  S-boxes per state (state width per share = 4*NSBOX)
//  LANES   4   masked S-box instances per cycle; must divide NSBOX, 1..NSBOX
//  (local) NCHUNK = NSBOX/LANES; CW = $clog2(NCHUNK+1) counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous reset, active low
//  in_valid   in   1        input state valid
//  in_ready   out  1        block can accept a state
//  in_sh0     in   4*NSBOX  input share 0; S-box j at bits [4j+3:4j]
//  in_sh1     in   4*NSBOX  input share 1
//  in_sh2     in   4*NSBOX  input share 2
//  out_valid  out  1        output state valid
//  out_ready  in   1        consumer accepts output
//  out_sh0    out  4*NSBOX  output share 0 (registered)
//  out_sh1    out  4*NSBOX  output share 1 (registered)
//  out_sh2    out  4*NSBOX  output share 2 (registered)
//  busy       out  1        FSM not IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, counters=0, share registers=0, out_valid=0, busy=0;
//    in_ready=1 after release. Reset mid-RUN/DONE discards the state; no partial output escapes.
//  - FSM IDLE: in_ready=1. in_valid&in_ready loads the three share registers (one per share;
//    shares never combined) -> RUN, issue counter k=0.
//  - RUN: cycle k (k<NCHUNK) drives chunk k (S-boxes k*LANES..k*LANES+LANES-1) into the
//    lanes; lane coordinate-function outputs are captured in the lane register stage.
//    Next cycle the compressed result is written back over chunk k (write pointer = k-1).
//    Issue and write-back overlap; RUN lasts NCHUNK+1 cycles -> DONE.
//  - DONE: out_valid=1, out_sh* = share registers; held stable until out_ready=1, then IDLE.
//    in_ready=0 in RUN and DONE; in_valid outside IDLE is ignored.
//  - Latency: accept edge to out_valid high = NCHUNK+1 cycles (LANES=4,NSBOX=16: 5).
//  - Per lane, per share i: out bits [3:1] = XOR_3 of the three registered CF terms of the
//    existing 27-term NF_CF_2 set (9 per output bit). Bit [0] = registered input bit [3]
//    of the same share (linear, non-complete).
//  - Recombined out (sh0^sh1^sh2) = RECT_G(in_sh0^in_sh1^in_sh2) per nibble.
//  - CF register stage is the glitch barrier; nothing combinational from inputs reaches XOR_3.
//  - NSBOX%LANES!=0 or LANES outside 1..NSBOX: elaboration error.
// STRUCTURE
//  - Shared package masked_rect_pkg: RECT_G_TABLE[16] golden table, share-count constant
//    NSHARE=3, FSM state enum {IDLE,RUN,DONE}.
//  - Sub-module masked_rectangle_g_sbox_3sh: one 3-share S-box with NF_CF_2 x27, 27-bit CF
//    register, 3-bit bit0 register, XOR_3 x9. Generate LANES copies. Top holds FSM,
//    counters, share registers and chunk muxing.
// TESTING
//  - NSBOX=16, LANES=4, all shares random, x=in_sh0^in_sh1^in_sh2 -> out_valid 5 cycles after
//    accept; every nibble's recombined out = RECT_G_TABLE[x]; nibble x=4'h8 gives out bit0=1.
//  - Exhaustive: each S-box position gets each of x=0..F under 100 random sharings ->
//    recombination matches table; out_sh* never equal an unshared value by construction check.
//  - Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_sh* stable,
//    in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  - rst_n pulse at RUN cycle 2 -> out_valid=0, busy=0, shares=0 immediately; next accepted
//    state completes correctly with full 5-cycle latency.
//  - LANES=16 -> latency 2; LANES=1 -> latency 17; both bit-exact vs table.
//  - Back-to-back states with in_valid held high -> second accepted only in IDLE after
//    first out handshake; no overlap or corruption between states.

Source files
------------

// File: rtl/masked_rect_pkg.sv
// Shared definitions for the 3-share masked RECTANGLE G-class S-box layer:
// share count, the unmasked golden table and the layer FSM states.
package masked_rect_pkg;

  localparam int NSHARE = 3;

  // Unmasked G-class S-box. Coordinate functions:
  //   y0 = x3
  //   y1 = x0 ^ x3 ^ x1.x2
  //   y2 = x1 ^ x2.x3
  //   y3 = x2 ^ x3 ^ 1
  localparam logic [3:0] RECT_G_TABLE [16] = '{
    4'h8, 4'hA, 4'hC, 4'hE, 4'h0, 4'h2, 4'h6, 4'h4,
    4'h3, 4'h1, 4'h7, 4'h5, 4'hF, 4'hD, 4'h9, 4'hB
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/masked_rectangle_g_sbox_3sh.sv
// One 3-share masked G-class S-box. The 27 cross-share coordinate-function
// terms are registered (glitch barrier) and compressed by XOR_3 per output
// share and bit. Bit 0 is linear and simply registered per share.
module masked_rectangle_g_sbox_3sh
  import masked_rect_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [NSHARE-1:0][3:0] sh_i,
  output logic [NSHARE-1:0][3:0] sh_o
);

  // cf_*[b][p][q]: output bit b+1, output share p, term built from shares p and q.
  logic [2:0][NSHARE-1:0][NSHARE-1:0] cf_d, cf_q;
  logic [NSHARE-1:0]                  b0_d, b0_q;

  // Coordinate-function terms: each cross product a_p.b_q lands in output
  // share p; linear parts and the constant sit on the diagonal terms only.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cf_d = '0;
    b0_d = '0;
    for (int p = 0; p < NSHARE; p++) begin
      b0_d[p] = sh_i[p][3];
      for (int q = 0; q < NSHARE; q++) begin
        cf_d[0][p][q] = sh_i[p][2] & sh_i[q][1];
        cf_d[1][p][q] = sh_i[p][3] & sh_i[q][2];
        if (p == q) begin
          cf_d[0][p][q] = cf_d[0][p][q] ^ sh_i[p][0] ^ sh_i[p][3];
          cf_d[1][p][q] = cf_d[1][p][q] ^ sh_i[p][1];
          cf_d[2][p][q] = sh_i[p][2] ^ sh_i[p][3] ^ (p == 0);
        end
      end
    end
  end

  // CF register stage: the only path from the lane inputs to the compression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= '0;
      b0_q <= '0;
    end else if (en_i) begin
      // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
      cf_q <= cf_d;
      b0_q <= b0_d;
    end
  end

  // XOR_3 compression of the three registered terms per output share and bit.
  always_comb begin
    sh_o = '0;
    for (int p = 0; p < NSHARE; p++) begin
      sh_o[p] = {^cf_q[2][p], ^cf_q[1][p], ^cf_q[0][p], b0_q[p]};
    end
  end

endmodule

// File: rtl/masked_rectangle_g_layer_3sh.sv
// 3-share masked G-class S-box layer. The full state is loaded into three
// share registers, then LANES S-boxes walk over it chunk by chunk: chunk k
// is issued while chunk k-1 is written back in place. Result is presented
// with a valid/ready handshake and held until consumed.
module masked_rectangle_g_layer_3sh
  import masked_rect_pkg::*;
#(
  parameter int NSBOX = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*NSBOX-1:0] in_sh0,
  input  logic [4*NSBOX-1:0] in_sh1,
  input  logic [4*NSBOX-1:0] in_sh2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*NSBOX-1:0] out_sh0,
  output logic [4*NSBOX-1:0] out_sh1,
  output logic [4*NSBOX-1:0] out_sh2,
  output logic               busy
);

  localparam int W      = 4 * NSBOX;
  localparam int NCHUNK = (LANES > 0) ? NSBOX / LANES : 1;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK);

  if (LANES < 1 || LANES > NSBOX || (NSBOX % LANES) != 0) begin : g_bad_cfg
    $error("masked_rectangle_g_layer_3sh: LANES must divide NSBOX and lie in 1..NSBOX");
  end

  state_e                              st_q;
  logic [CW-1:0]                       k_q;
  logic                                in_ready_q, out_valid_q, busy_q;
  logic [NSHARE-1:0][W-1:0]            sh_q, sh_d;
  logic [LANES-1:0][NSHARE-1:0][3:0]   lane_in, lane_out;
  logic                                accept, issue_en, wb_en;
  int                                  issue_idx, wb_idx;

  // Handshake and chunk pointers: issue pointer is k, write-back pointer k-1.
  always_comb begin
    accept    = in_valid & in_ready_q;
    issue_en  = (st_q == RUN) && (k_q < LAST_K);
    wb_en     = (st_q == RUN) && (k_q != '0);
    issue_idx = issue_en ? int'(k_q) : 0;
    wb_idx    = wb_en ? int'(k_q) - 1 : 0;
  end

  // Select the issued chunk of every share into the lanes; shares stay separate.
  always_comb begin
    lane_in = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < NSHARE; s++) begin
        lane_in[l][s] = sh_q[s][(issue_idx * LANES + l) * 4 +: 4];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    masked_rectangle_g_sbox_3sh u_sbox (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (issue_en),
      .sh_i  (lane_in[l]),
      .sh_o  (lane_out[l])
    );
  end

  // Share register next state: load on accept, in-place write-back during RUN.
  always_comb begin
    sh_d = sh_q;
    if (accept) begin
      sh_d[0] = in_sh0;
      sh_d[1] = in_sh1;
      sh_d[2] = in_sh2;
    end else if (wb_en) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < NSHARE; s++) begin
          sh_d[s][(wb_idx * LANES + l) * 4 +: 4] = lane_out[l][s];
        end
      end
    end
  end

  // Share registers; cleared on reset so a discarded state never reappears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the state registers are reset explicitly because a reset must not leave old shares visible at the outputs.
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  // Layer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          if (accept) begin
            st_q       <= RUN;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (k_q == LAST_K) begin
            st_q        <= DONE;
            k_q         <= '0;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          st_q        <= IDLE;
          k_q         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sh0   = sh_q[0];
  assign out_sh1   = sh_q[1];
  assign out_sh2   = sh_q[2];

endmodule
